// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the data-memory port arbiter.
package dmem_arb_pkg;

   localparam logic PORT_M = 1'b0;
   localparam logic PORT_I = 1'b1;

   localparam int unsigned STARVE_MAX_DFLT = 4;
   localparam int unsigned AW_DFLT         = 32;

   // Address field is sized for the default width; narrower AW slices it down.
   typedef struct packed {
      logic [AW_DFLT-1:0] addr;
      logic [3:0]         wen;
      logic [31:0]        wdata;
   } dmem_req_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of both requester ports (M and I) plus the RAM macro side of the arbiter.
interface dmem_port_arbiter_if
   import dmem_arb_pkg::*;
#(
   parameter int unsigned AW = AW_DFLT
);
   logic          m_req;
   logic [AW-1:0] m_addr;
   logic [3:0]    m_wen;
   logic [31:0]   m_wdata;
   logic          m_gnt;
   logic          m_rvalid;
   logic [31:0]   m_rdata;

   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [3:0]    i_wen;
   logic [31:0]   i_wdata;
   logic          i_gnt;
   logic          i_rvalid;
   logic [31:0]   i_rdata;

   logic          ram_en;
   logic [3:0]    ram_wen;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata;

   // Arbiter side.
   modport slave (
      input  m_req, m_addr, m_wen, m_wdata,
      output m_gnt, m_rvalid, m_rdata,
      input  i_req, i_addr, i_wen, i_wdata,
      output i_gnt, i_rvalid, i_rdata,
      output ram_en, ram_wen, ram_addr, ram_wdata,
      input  ram_rdata
   );

   // Requesters and RAM macro side.
   modport master (
      output m_req, m_addr, m_wen, m_wdata,
      input  m_gnt, m_rvalid, m_rdata,
      output i_req, i_addr, i_wen, i_wdata,
      input  i_gnt, i_rvalid, i_rdata,
      input  ram_en, ram_wen, ram_addr, ram_wdata,
      output ram_rdata
   );

endinterface

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of consecutive cycles port I was denied; flags when I must win.
module dmem_arb_starve_cnt
   import dmem_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DFLT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_req,
   input  logic       i_gnt,
   output logic [3:0] starve_cnt,
   output logic       starve_hit
);

   localparam logic [3:0] MaxCnt = 4'(STARVE_MAX);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!i_req || i_gnt) begin
         cnt_d = '0;
      end else if (cnt_q != MaxCnt) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign starve_cnt = cnt_q;
   assign starve_hit = (cnt_q == MaxCnt);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter onto one synchronous-read data RAM; M has priority, I has a
// starvation override. Read responses are steered back by a one-entry tag.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DFLT,
   parameter int unsigned AW         = AW_DFLT
) (
   input logic                clk,
   input logic                reset,
   dmem_port_arbiter_if.slave bus
);

   logic        m_gnt, i_gnt, any_gnt;
   logic [3:0]  starve_cnt;
   logic        starve_hit;
   dmem_req_t   m_bundle, i_bundle, sel;

   logic [AW-1:0] hold_addr_q;
   logic [31:0]   hold_wdata_q;

   logic        tag_v_q, tag_v_d;
   logic        tag_q, tag_d;
   logic        m_rv, i_rv;
   logic [31:0] m_rdata_q, i_rdata_q;

   dmem_arb_starve_cnt #(
      .STARVE_MAX(STARVE_MAX)
   ) u_starve (
      .clk       (clk),
      .reset     (reset),
      .i_req     (bus.i_req),
      .i_gnt     (i_gnt),
      .starve_cnt(starve_cnt),
      .starve_hit(starve_hit)
   );

   always_comb begin
      m_gnt = 1'b0;
      i_gnt = 1'b0;
      if (!reset) begin
         if (bus.m_req && bus.i_req) begin
            if (starve_hit) i_gnt = 1'b1;
            else            m_gnt = 1'b1;
         end else if (bus.m_req) begin
            m_gnt = 1'b1;
         end else if (bus.i_req) begin
            i_gnt = 1'b1;
         end
      end
   end

   assign any_gnt = m_gnt | i_gnt;

   always_comb begin
      m_bundle = '{addr: AW_DFLT'(bus.m_addr), wen: bus.m_wen, wdata: bus.m_wdata};
      i_bundle = '{addr: AW_DFLT'(bus.i_addr), wen: bus.i_wen, wdata: bus.i_wdata};
      sel      = i_gnt ? i_bundle : m_bundle;
   end

   // Address/data hold their last granted value so the RAM pins stay quiet when idle.
   always_comb begin
      bus.ram_en    = any_gnt;
      bus.ram_wen   = 4'b0000;
      bus.ram_addr  = hold_addr_q;
      bus.ram_wdata = hold_wdata_q;
      if (any_gnt) begin
         bus.ram_wen   = sel.wen;
         bus.ram_addr  = sel.addr[AW-1:0];
         bus.ram_wdata = sel.wdata;
      end
   end

   always_comb begin
      tag_v_d = any_gnt && (sel.wen == 4'b0000);
      tag_d   = i_gnt ? PORT_I : PORT_M;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_addr_q  <= '0;
         hold_wdata_q <= '0;
         tag_v_q      <= 1'b0;
         tag_q        <= PORT_M;
      end else begin
         if (any_gnt) begin
            hold_addr_q  <= sel.addr[AW-1:0];
            hold_wdata_q <= sel.wdata;
         end
         tag_v_q <= tag_v_d;
         tag_q   <= tag_d;
      end
   end

   // Gating with reset drops a read that was in flight when reset arrived.
   assign m_rv = tag_v_q && (tag_q == PORT_M) && !reset;
   assign i_rv = tag_v_q && (tag_q == PORT_I) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         m_rdata_q <= '0;
         i_rdata_q <= '0;
      end else begin
         if (m_rv) m_rdata_q <= bus.ram_rdata;
         if (i_rv) i_rdata_q <= bus.ram_rdata;
      end
   end

   assign bus.m_gnt    = m_gnt;
   assign bus.i_gnt    = i_gnt;
   assign bus.m_rvalid = m_rv;
   assign bus.i_rvalid = i_rv;
   assign bus.m_rdata  = m_rv ? bus.ram_rdata : m_rdata_q;
   assign bus.i_rdata  = i_rv ? bus.ram_rdata : i_rdata_q;

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares one single-ported, synchronous-read data RAM (1-cycle read latency, byte write enables) between two requesters: the MEM stage (port M) and the instruction-fetch / refill path (port I).
- Arbitration is fixed priority to M, with an anti-starvation override for I.
- Each read response is routed back to the port that issued it and held stable in a per-port data register.
- Sits between the pipeline stages and the RAM macro; the MEM-stage load/store byte logic is unchanged and drives port M.

Parameters:
- STARVE_MAX, 4: number of consecutive cycles I may be denied while requesting before I wins the next contended cycle; legal range 1..15.
- AW, 32: address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m_req  in  1  MEM-stage request; held with stable fields until m_gnt
- m_addr  in  AW  byte address
- m_wen  in  4  byte write enables; 0 means read
- m_wdata  in  32  write data, already lane-aligned
- m_gnt  out  1  combinational accept, same cycle
- m_rvalid  out  1  one-cycle pulse; m_rdata is new this cycle
- m_rdata  out  32  read data, held until the next M read response
- i_req, i_addr, i_wen, i_wdata, i_gnt, i_rvalid, i_rdata  same widths and meanings for port I
- ram_en  out  1  RAM access strobe
- ram_wen  out  4  RAM byte write enables
- ram_addr  out  AW  RAM address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid the cycle after a read strobe

Behaviour:
- Reset values: m_gnt=0, i_gnt=0, m_rvalid=0, i_rvalid=0, m_rdata=0, i_rdata=0, ram_en=0, ram_wen=0. Internal state also clears: starvation counter, response tag, tag-valid.
- Reset asserted mid-operation: an in-flight read is dropped, so no rvalid pulse occurs the following cycle.
- While reset is high, both gnt outputs are 0.
- Grant is combinational from req, the counter and reset. At most one gnt per cycle.
  - Only M requesting: M granted.
  - Only I requesting: I granted.
  - Both requesting: M granted, unless starve_cnt == STARVE_MAX, in which case I is granted.
- Starvation counter (4 bits):
  - Increments when i_req=1 and i_gnt=0, saturating at STARVE_MAX.
  - Clears to 0 on any i_gnt, or when i_req=0.
- RAM drive: ram_en = m_gnt | i_gnt. ram_wen, ram_addr and ram_wdata are muxed from the granted port. When nothing is granted: ram_wen=0, and address and data hold the last muxed value.
- Response pipeline, one tag register:
  - Tag stage loads on a granted read (wen==0): tag_v=1, tag = port id.
  - Otherwise tag_v=0.
  - Next cycle, if tag_v: the tagged port's rdata register captures ram_rdata and its rvalid pulses for exactly 1 cycle. The other port's rdata holds.
- Writes: granted in one cycle, no rvalid, rdata registers unchanged.
- Throughput: one access per cycle. Back-to-back reads, including alternating ports, are legal. A response and a new grant occur in the same cycle without conflict.
- Read-after-write to the same address in consecutive cycles returns the new data; this relies on the RAM's write-then-read ordering, and the block adds no bypass.
- Protocol violation (req dropped before gnt) has no defined response. The bench only flags it.

Decomposition:
- Shared package `dmem_arb_pkg`:
  - port-id constants PORT_M=1'b0, PORT_I=1'b1
  - request bundle typedef {addr, wen, wdata}
  - STARVE_MAX default constant
- Natural sub-module: `dmem_arb_starve_cnt`, the saturating counter plus the override flag. The mux and tag pipeline stay in the top level.

Test Plan:
- Reset mid-read: M read to 0x100 granted, reset high the next cycle -> m_rvalid stays 0, and all outputs are at reset values one cycle after reset.
- Single M read: RAM[0x40]=0xDEADBEEF, m_req read 0x40 -> m_gnt same cycle; m_rvalid=1 and m_rdata=0xDEADBEEF next cycle; m_rdata still 0xDEADBEEF 5 cycles later.
- Write then read on port I: i_wen=4'b0010 to 0x8 with data 0x0000AB00, then read 0x8 next cycle -> i_rvalid one cycle later with byte1=0xAB; no rvalid for the write.
- Contention priority: m_req and i_req both held, M issuing reads, STARVE_MAX=4 -> M granted 4 cycles, I granted cycle 5, counter cleared, M granted cycle 6.
- Alternating reads: M read 0x10 then I read 0x20 back-to-back -> m_rvalid in cycle 2 and i_rvalid in cycle 3, each with the correct data; the other port's rdata is unchanged.
- Idle: no requests for 10 cycles -> ram_en=0, ram_wen=0, no rvalid, starve_cnt=0.
